// File: rtl/std_sram_pkg.sv
// rtl/std_sram_pkg.sv - shared types, constants and helpers for the standard SRAM initiator
// Purpose: READ_LATENCY legal values, request opcode type, initiator state encoding,
//          credit-counter width helper.
// Ports:   none (package).
package std_sram_pkg;

  // Legal READ_LATENCY values: bare macro, or macro followed by an output DFF.
  localparam int SRAM_RL_BARE = 1;
  localparam int SRAM_RL_DFF  = 2;

  // Request opcode as carried on req_we.
  typedef enum logic {
    REQ_READ  = 1'b0,
    REQ_WRITE = 1'b1
  } req_op_e;

  // Issue-side state: OFF right after reset, OPEN accepting requests,
  // HOLD repeating the last read so the output DFF captures it.
  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_OPEN = 2'd1,
    ST_HOLD = 2'd2
  } init_state_e;

  // Width of a counter that must represent 0..depth inclusive.
  function automatic int crd_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/std_fifo_sync.sv
// rtl/std_fifo_sync.sv - single-clock response FIFO
// Purpose: DATA_WIDTH x DEPTH first-word-fall-through FIFO, DEPTH a power of 2 (>= 2).
// Ports:   clk, aresetn (async, active-low)
//          push, push_data   - write side
//          pop, pop_data     - read side, pop_data shows the head entry
//          empty             - no entry stored
// A push into a full FIFO without a simultaneous pop is flagged by an assertion.
module std_fifo_sync #(
  parameter int DATA_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  empty
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW:0]           wr_ptr;
  logic [PW:0]           rd_ptr;
  logic                  full;
  logic                  do_push;
  logic                  do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[PW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + (PW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + (PW+1)'(1);
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!aresetn) !(push && full && !pop));

endmodule

// File: rtl/std_sram_singleport_initiator.sv
// rtl/std_sram_singleport_initiator.sv - credit-based request/response initiator for a single-port SRAM
// Purpose: turns valid/ready requests into SRAM port cycles and returns read data in order
//          through a response FIFO; credits guarantee the FIFO never overflows.
// Ports:   clk, aresetn (async, active-low)
//          req_valid/req_ready/req_we/req_addr/req_wdata - request channel
//          rsp_valid/rsp_ready/rsp_rdata                 - read response channel
//          sram_en/sram_we/sram_addr/sram_din/sram_dout  - SRAM port
//          busy - a read is in flight or a response is buffered
// Option:  STD_SRAM_INITIATOR_RSP_BYPASS_EN - when defined, arriving read data skips an empty
//          FIFO and drives rsp_valid/rsp_rdata combinationally.
module std_sram_singleport_initiator
  import std_sram_pkg::*;
#(
  parameter int ADDR_WIDTH   = 1,
  parameter int DATA_WIDTH   = 1,
  parameter int READ_LATENCY = 2,
  parameter int RSP_DEPTH    = 2
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout,
  output logic                  busy
);

  localparam int CW      = crd_width(RSP_DEPTH);
  localparam bit HOLD_EN = (READ_LATENCY == SRAM_RL_DFF);

  init_state_e             state;
  init_state_e             state_nxt;
  logic [CW-1:0]           crd;
  logic [READ_LATENCY-1:0] vld_sr;
  logic [ADDR_WIDTH-1:0]   last_raddr;
  logic                    acc;
  logic                    rd_acc;
  logic                    rsp_hs;
  logic                    arrive;
  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    fifo_empty;
  logic [DATA_WIDTH-1:0]   fifo_rdata;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state <= ST_OFF;
    end else begin
      state <= state_nxt;
    end
  end

  // req_ready depends only on state and crd, never on the request itself.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    acc       = 1'b0;
    sram_en   = 1'b0;
    sram_we   = 1'b0;
    sram_addr = '0;
    sram_din  = '0;
    case (state)
      ST_OFF: begin
        state_nxt = ST_OPEN;
      end
      ST_OPEN: begin
        req_ready = (crd != '0);
        acc       = req_valid & req_ready;
        sram_en   = acc;
        sram_we   = req_we;
        sram_addr = req_addr;
        sram_din  = req_wdata;
        if (HOLD_EN && acc && (req_op_e'(req_we) == REQ_READ)) begin
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Re-read the same word so the output DFF sees en & ~we on its capture edge.
        sram_en   = 1'b1;
        sram_we   = 1'b0;
        sram_addr = last_raddr;
        state_nxt = ST_OPEN;
      end
      default: begin
        state_nxt = ST_OFF;
      end
    endcase
  end

  assign rd_acc = acc & (req_op_e'(req_we) == REQ_READ);
  assign rsp_hs = rsp_valid & rsp_ready;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      last_raddr <= '0;
    end else if (rd_acc) begin
      last_raddr <= req_addr;
    end
  end

  // One credit per buffered-or-in-flight read; writes are free.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      crd <= CW'(RSP_DEPTH);
    end else if (rd_acc && !rsp_hs) begin
      crd <= crd - CW'(1);
    end else if (!rd_acc && rsp_hs) begin
      crd <= crd + CW'(1);
    end
  end

  // Read-in-flight tracker; the last stage marks sram_dout as valid.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      vld_sr <= '0;
    end else begin
      vld_sr[0] <= rd_acc;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_sr[i] <= vld_sr[i-1];
      end
    end
  end

  assign arrive = vld_sr[READ_LATENCY-1];

`ifdef STD_SRAM_INITIATOR_RSP_BYPASS_EN
  logic byp;

  // Empty FIFO: present arriving data directly; if taken now, it never enters the FIFO.
  assign byp       = fifo_empty & arrive;
  assign rsp_valid = ~fifo_empty | arrive;
  assign rsp_rdata = byp ? sram_dout : fifo_rdata;
  assign fifo_push = arrive & ~(byp & rsp_ready);
  assign fifo_pop  = ~fifo_empty & rsp_ready;
`else
  assign rsp_valid = ~fifo_empty;
  assign rsp_rdata = fifo_rdata;
  assign fifo_push = arrive;
  assign fifo_pop  = rsp_hs;
`endif

  std_fifo_sync #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .aresetn   (aresetn),
    .push      (fifo_push),
    .push_data (sram_dout),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .empty     (fifo_empty)
  );

  assign busy = (|vld_sr) | ~fifo_empty;

endmodule

// File: tb/tb_std_sram_singleport_initiator.sv
// tb/tb_std_sram_singleport_initiator.sv - self-checking bench for std_sram_singleport_initiator
`timescale 1ns/1ps
module tb_std_sram_singleport_initiator;

  localparam int AW = 4;
  localparam int DW = 8;
`ifdef STD_SRAM_INITIATOR_RSP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  always #5 clk = ~clk;

  // a_*: RL=2, RSP_DEPTH=2 instance; b_*: RL=1, RSP_DEPTH=4 instance
  logic a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready, a_en, a_we, a_busy;
  logic [AW-1:0] a_req_addr, a_addr;
  logic [DW-1:0] a_req_wdata, a_rsp_rdata, a_din, a_dout;
  logic b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_en, b_we, b_busy;
  logic [AW-1:0] b_req_addr, b_addr;
  logic [DW-1:0] b_req_wdata, b_rsp_rdata, b_din, b_dout;

  std_sram_singleport_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(2), .RSP_DEPTH(2)) u_a (
    .clk(clk), .aresetn(aresetn), .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_rdata(a_rsp_rdata), .sram_en(a_en), .sram_we(a_we), .sram_addr(a_addr), .sram_din(a_din),
    .sram_dout(a_dout), .busy(a_busy));

  std_sram_singleport_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1), .RSP_DEPTH(4)) u_b (
    .clk(clk), .aresetn(aresetn), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_rdata(b_rsp_rdata), .sram_en(b_en), .sram_we(b_we), .sram_addr(b_addr), .sram_din(b_din),
    .sram_dout(b_dout), .busy(b_busy));

  typedef logic [7:0] mem_t [16];
  function automatic mem_t mk_mem(input logic [7:0] base);
    mem_t m;
    for (int i = 0; i < 16; i++) m[i] = base + 8'(i);
    return m;
  endfunction

  // SRAM models: array read into q1; q2 is the output DFF, both capture only on en & ~we.
  mem_t mem_a = mk_mem(8'hA0);
  mem_t mem_b = mk_mem(8'h40);
  logic [DW-1:0] a_q1, a_q2, b_q1;
  always @(posedge clk) begin
    if (a_en) begin
      if (a_we) mem_a[a_addr] <= a_din;
      else begin a_q1 <= mem_a[a_addr]; a_q2 <= a_q1; end
    end
    if (b_en) begin
      if (b_we) mem_b[b_addr] <= b_din;
      else b_q1 <= mem_b[b_addr];
    end
  end
  assign a_dout = a_q2;
  assign b_dout = b_q1;

  int n_chk = 0;
  int n_pass = 0;
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  typedef struct {
    logic v, we; logic [3:0] ad; logic [7:0] wd; logic rr;
    logic x_rdy, x_en, x_we; logic [3:0] x_ad; logic x_rv; logic [7:0] x_rd; logic x_busy;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic we, input logic [3:0] ad, input logic [7:0] wd,
                              input logic rr, input logic x_rdy, input logic x_en, input logic x_we,
                              input logic [3:0] x_ad, input logic x_rv, input logic [7:0] x_rd,
                              input logic x_busy);
    vec_t t;
    t.v = v; t.we = we; t.ad = ad; t.wd = wd; t.rr = rr;
    t.x_rdy = x_rdy; t.x_en = x_en; t.x_we = x_we; t.x_ad = x_ad;
    t.x_rv = x_rv; t.x_rd = x_rd; t.x_busy = x_busy;
    return t;
  endfunction

  vec_t tbl[15];
  mem_t sh;
  logic [7:0] expq[$];
  int n_acc, got, nreq, cyc;
  logic taken;

  initial begin
    //          v  we ad    wd     rr | rdy en we x_ad  rv    rd     busy
    tbl[0]  = mk(H, H, 4'd3, 8'h5A, L,  L,  L, L, 4'd0, L,    8'h00, L);
    tbl[1]  = mk(H, H, 4'd3, 8'h5A, L,  H,  H, H, 4'd3, L,    8'h00, L);
    tbl[2]  = mk(H, L, 4'd3, 8'h00, L,  H,  H, L, 4'd3, L,    8'h00, L);
    tbl[3]  = mk(H, H, 4'd7, 8'h33, L,  L,  H, L, 4'd3, L,    8'h00, H);
    tbl[4]  = mk(H, H, 4'd7, 8'h33, L,  H,  H, H, 4'd7, BYP,  8'h5A, H);
    tbl[5]  = mk(H, L, 4'd7, 8'h00, L,  H,  H, L, 4'd7, H,    8'h5A, H);
    tbl[6]  = mk(H, L, 4'd1, 8'h00, L,  L,  H, L, 4'd7, H,    8'h5A, H);
    tbl[7]  = mk(H, L, 4'd1, 8'h00, L,  L,  L, L, 4'd0, H,    8'h5A, H);
    tbl[8]  = mk(H, L, 4'd1, 8'h00, L,  L,  L, L, 4'd0, H,    8'h5A, H);
    tbl[9]  = mk(H, L, 4'd1, 8'h00, H,  L,  L, L, 4'd0, H,    8'h5A, H);
    tbl[10] = mk(H, L, 4'd1, 8'h00, L,  H,  H, L, 4'd1, H,    8'h33, H);
    tbl[11] = mk(H, L, 4'd2, 8'h00, H,  L,  H, L, 4'd1, H,    8'h33, H);
    tbl[12] = mk(L, L, 4'd0, 8'h00, H,  H,  L, L, 4'd0, BYP,  8'hA1, H);
    tbl[13] = mk(L, L, 4'd0, 8'h00, H,  H,  L, L, 4'd0, ~BYP, 8'hA1, ~BYP);
    tbl[14] = mk(L, L, 4'd0, 8'h00, L,  H,  L, L, 4'd0, L,    8'h00, L);

    // Reset state with non-zero inputs applied
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 4'hF; a_req_wdata = 8'hFF; a_rsp_ready = 1'b1;
    b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 4'hF; b_req_wdata = 8'hFF; b_rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst req_ready", int'(a_req_ready), 0);
    chk("rst rsp_valid", int'(a_rsp_valid), 0);
    chk("rst sram_en", int'(a_en), 0);
    chk("rst sram_we", int'(a_we), 0);
    chk("rst busy", int'(a_busy), 0);
    chk("rst sram_addr", int'(a_addr), 0);
    chk("rst sram_din", int'(a_din), 0);
    chk("rst rsp_rdata", int'(a_rsp_rdata), 0);
    b_req_valid = 1'b0; b_rsp_ready = 1'b0;

    // Directed table on the RL=2 / depth-2 instance
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (k == 0) aresetn = 1'b1;
      a_req_valid = tbl[k].v; a_req_we = tbl[k].we; a_req_addr = tbl[k].ad;
      a_req_wdata = tbl[k].wd; a_rsp_ready = tbl[k].rr;
      #1;
      chk($sformatf("v%0d req_ready", k), int'(a_req_ready), int'(tbl[k].x_rdy));
      chk($sformatf("v%0d sram_en", k), int'(a_en), int'(tbl[k].x_en));
      if (tbl[k].x_en) begin
        chk($sformatf("v%0d sram_we", k), int'(a_we), int'(tbl[k].x_we));
        chk($sformatf("v%0d sram_addr", k), int'(a_addr), int'(tbl[k].x_ad));
        if (tbl[k].x_we) chk($sformatf("v%0d sram_din", k), int'(a_din), int'(tbl[k].wd));
      end
      chk($sformatf("v%0d rsp_valid", k), int'(a_rsp_valid), int'(tbl[k].x_rv));
      if (tbl[k].x_rv) chk($sformatf("v%0d rsp_rdata", k), int'(a_rsp_rdata), int'(tbl[k].x_rd));
      chk($sformatf("v%0d busy", k), int'(a_busy), int'(tbl[k].x_busy));
    end

    // Streaming 16 reads on the RL=1 / depth-4 instance
    b_rsp_ready = 1'b1; b_req_we = 1'b0;
    for (int i = 0; i < 20; i++) begin
      int s;
      s = BYP ? 1 : 2;
      @(negedge clk);
      b_req_valid = (i < 16); b_req_addr = 4'(i);
      #1;
      if (i < 16) chk($sformatf("stream%0d req_ready", i), int'(b_req_ready), 1);
      chk($sformatf("stream%0d rsp_valid", i), int'(b_rsp_valid), int'(i >= s && i < s + 16));
      if (i >= s && i < s + 16) chk($sformatf("stream%0d rsp_rdata", i), int'(b_rsp_rdata), 'h40 + i - s);
    end

    // Reset mid-burst with reads in flight / buffered
    b_rsp_ready = 1'b0;
    @(negedge clk); b_req_valid = 1'b1; b_req_addr = 4'd1;
    @(negedge clk); b_req_addr = 4'd2;
    #1; chk("burst busy before reset", int'(b_busy), 1);
    @(negedge clk); b_req_valid = 1'b0; aresetn = 1'b0;
    #1;
    chk("mid rst req_ready", int'(b_req_ready), 0);
    chk("mid rst rsp_valid", int'(b_rsp_valid), 0);
    chk("mid rst sram_en", int'(b_en), 0);
    chk("mid rst sram_we", int'(b_we), 0);
    chk("mid rst busy", int'(b_busy), 0);
    chk("mid rst sram_addr", int'(b_addr), 0);
    chk("mid rst sram_din", int'(b_din), 0);
    chk("mid rst rsp_rdata", int'(b_rsp_rdata), 0);
    @(negedge clk); aresetn = 1'b1; b_rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk($sformatf("post rst%0d rsp_valid", i), int'(b_rsp_valid), 0);
    end
    b_rsp_ready = 1'b0; n_acc = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); b_req_valid = 1'b1; b_req_addr = 4'(i);
      #1; if (b_req_ready) n_acc++;
    end
    chk("post rst credits", n_acc, 4);
    @(negedge clk); b_req_valid = 1'b0; b_rsp_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (b_rsp_valid) begin
        chk($sformatf("credit drain%0d", got), int'(b_rsp_rdata), 'h40 + got);
        got++;
      end
      @(negedge clk);
    end
    chk("credit drain count", got, 4);

    // Random mix with backpressure on the RL=2 instance, scoreboarded
    sh = mk_mem(8'hA0); sh[3] = 8'h5A; sh[7] = 8'h33;
    a_req_valid = 1'b0; taken = 1'b0; nreq = 0; cyc = 0;
    while (nreq < 1000 && cyc < 20000) begin
      @(negedge clk); cyc++;
      if (!a_req_valid || taken) begin
        a_req_valid = ($urandom_range(0, 3) != 0);
        a_req_we    = 1'($urandom_range(0, 1));
        a_req_addr  = 4'($urandom_range(0, 7));
        a_req_wdata = 8'($urandom);
      end
      taken = 1'b0;
      a_rsp_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (a_rsp_valid && a_rsp_ready) begin
        chk("rand rsp expected", int'(expq.size() != 0), 1);
        if (expq.size() != 0) chk("rand rsp data", int'(a_rsp_rdata), int'(expq.pop_front()));
      end
      if (a_req_valid && a_req_ready) begin
        if (a_req_we) sh[a_req_addr] = a_req_wdata;
        else expq.push_back(sh[a_req_addr]);
        taken = 1'b1; nreq++;
      end
    end
    chk("rand requests accepted", nreq, 1000);
    @(negedge clk); a_req_valid = 1'b0; a_rsp_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (a_rsp_valid) begin
        chk("rand drain expected", int'(expq.size() != 0), 1);
        if (expq.size() != 0) chk("rand drain data", int'(a_rsp_rdata), int'(expq.pop_front()));
      end
      @(negedge clk);
    end
    #1;
    chk("rand leftover", expq.size(), 0);
    chk("rand busy", int'(a_busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
